// File: rtl/bicubic_window_fetch.sv
// bicubic_window_fetch: maps a target pixel to ROI source coordinates, divides out the
// fractions, fetches the clamped 4x4 neighbourhood from ImgROM and presents it over valid/ready.
module bicubic_window_fetch #(
  parameter int IMG_W = 100,
  parameter int IMG_H = 100
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [6:0]   V0,
  input  logic [6:0]   H0,
  input  logic [4:0]   SW,
  input  logic [4:0]   SH,
  input  logic [5:0]   TW,
  input  logic [5:0]   TH,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [5:0]   req_tx,
  input  logic [5:0]   req_ty,
  output logic         rom_cen,
  output logic [13:0]  rom_a,
  input  logic [7:0]   rom_q,
  output logic         win_valid,
  input  logic         win_ready,
  output logic [127:0] win_pix,
  output logic [5:0]   win_fx_num,
  output logic [5:0]   win_fx_den,
  output logic [5:0]   win_fy_num,
  output logic [5:0]   win_fy_den
);
  localparam logic [2:0] IDLE = 3'd0, DIV = 3'd1, FETCH = 3'd2, CAPT = 3'd3, VALID = 3'd4;
  logic [2:0] state;
  logic [3:0] cnt, cap_k;
  logic cap_v;
  logic [6:0] h0, v0, rx, ry;
  logic [4:0] sw, sh;
  logic [5:0] dx, dy;
  logic [10:0] nx, ny;
  logic [13:0] rom_a_q, addr;
  logic [7:0] rx_sh, ry_sh;
  logic x_ge, y_ge;
  logic signed [13:0] cc, rr, cl, rl, xlo, xhi, ylo, yhi;
  // nx/ny hold the dividend and shift in quotient bits; a zero divisor never subtracts
  always_comb begin
    rx_sh = {rx, nx[10]};
    ry_sh = {ry, ny[10]};
    x_ge = dx != 6'd0 && rx_sh >= {2'b0, dx};
    y_ge = dy != 6'd0 && ry_sh >= {2'b0, dy};
    xlo = $signed({7'b0, h0});
    ylo = $signed({7'b0, v0});
    xhi = xlo + $signed({9'b0, sw}) - 14'sd1;
    yhi = ylo + $signed({9'b0, sh}) - 14'sd1;
    cc = xlo + $signed({3'b0, nx}) + $signed({12'b0, cnt[1:0]}) - 14'sd1;
    rr = ylo + $signed({3'b0, ny}) + $signed({12'b0, cnt[3:2]}) - 14'sd1;
    cl = cc < xlo ? xlo : cc > xhi ? xhi : cc;
    rl = rr < ylo ? ylo : rr > yhi ? yhi : rr;
    addr = 14'(int'(rl[7:0]) * IMG_W + int'(cl[7:0]));
  end
  assign req_ready = state == IDLE;
  assign win_valid = state == VALID;
  assign rom_cen = state != FETCH;
  assign rom_a = state == FETCH ? addr : rom_a_q;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      cnt <= '0;
      cap_k <= '0;
      cap_v <= 1'b0;
      {h0, v0, sw, sh, dx, dy} <= '0;
      {nx, ny, rx, ry} <= '0;
      rom_a_q <= '0;
      win_pix <= '0;
      {win_fx_num, win_fx_den, win_fy_num, win_fy_den} <= '0;
    end else begin
      cap_v <= state == FETCH;
      cap_k <= cnt;
      if (cap_v) win_pix[{cap_k, 3'b0} +: 8] <= rom_q;
      case (state)
        IDLE: if (req_valid) begin
          {h0, v0, sw, sh} <= {H0, V0, SW, SH};
          dx <= TW - 6'd1;
          dy <= TH - 6'd1;
          nx <= 11'(req_tx) * 11'(SW - 5'd1);
          ny <= 11'(req_ty) * 11'(SH - 5'd1);
          {rx, ry} <= '0;
          cnt <= '0;
          state <= DIV;
        end
        DIV: begin
          rx <= x_ge ? 7'(rx_sh - {2'b0, dx}) : rx_sh[6:0];
          ry <= y_ge ? 7'(ry_sh - {2'b0, dy}) : ry_sh[6:0];
          nx <= {nx[9:0], x_ge};
          ny <= {ny[9:0], y_ge};
          cnt <= cnt == 4'd10 ? 4'd0 : cnt + 4'd1;
          state <= cnt == 4'd10 ? FETCH : DIV;
        end
        FETCH: begin
          rom_a_q <= addr;
          cnt <= cnt + 4'd1;
          state <= cnt == 4'd15 ? CAPT : FETCH;
        end
        CAPT: begin
          win_fx_num <= dx == 6'd0 ? 6'd0 : 6'(rx);
          win_fy_num <= dy == 6'd0 ? 6'd0 : 6'(ry);
          win_fx_den <= dx;
          win_fy_den <= dy;
          state <= VALID;
        end
        VALID: state <= win_ready ? IDLE : VALID;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bicubic_window_fetch.sv
// tb_bicubic_window_fetch: directed checks of latency, division, clamping, backpressure and reset.
module tb_bicubic_window_fetch;
  logic CLK = 0, RST = 1;
  logic [6:0] V0, H0;
  logic [4:0] SW, SH;
  logic [5:0] TW, TH, req_tx, req_ty;
  logic req_valid = 0, win_ready = 0;
  logic req_ready, rom_cen, win_valid;
  logic [13:0] rom_a;
  logic [7:0] rom_q = 0;
  logic [127:0] win_pix, sv;
  logic [5:0] win_fx_num, win_fx_den, win_fy_num, win_fy_den;
  int errors = 0, checks = 0, reads = 0, rd0, lat;
  logic stable;

  bicubic_window_fetch dut (
    .CLK(CLK), .RST(RST), .V0(V0), .H0(H0), .SW(SW), .SH(SH), .TW(TW), .TH(TH),
    .req_valid(req_valid), .req_ready(req_ready), .req_tx(req_tx), .req_ty(req_ty),
    .rom_cen(rom_cen), .rom_a(rom_a), .rom_q(rom_q),
    .win_valid(win_valid), .win_ready(win_ready), .win_pix(win_pix),
    .win_fx_num(win_fx_num), .win_fx_den(win_fx_den),
    .win_fy_num(win_fy_num), .win_fy_den(win_fy_den)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) if (!rom_cen) begin
    rom_q <= rom_a[7:0];
    reads <= reads + 1;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic [5:0] tx, input logic [5:0] ty, output int l);
    @(negedge CLK);
    req_tx = tx; req_ty = ty; req_valid = 1;
    @(posedge CLK);
    #1 req_valid = 0;
    l = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge CLK);
      #1;
      if (win_valid) begin
        l = i;
        break;
      end
    end
  endtask

  task automatic release_win();
    @(negedge CLK);
    win_ready = 1;
    @(posedge CLK);
    #1;
    chk("rel_valid", win_valid, 0);
    chk("rel_ready", req_ready, 1);
    win_ready = 0;
  endtask

  initial begin
    H0 = 10; V0 = 10; SW = 8; SH = 8; TW = 15; TH = 15; req_tx = 0; req_ty = 0;
    #12;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_rom_cen", rom_cen, 1);
    chk("rst_rom_a", rom_a, 0);
    chk("rst_win_pix", win_pix, 0);
    chk("rst_den", {win_fx_den, win_fy_den, win_fx_num, win_fy_num}, 0);
    @(negedge CLK) RST = 0;

    rd0 = reads;
    do_req(0, 0, lat);
    chk("t1_latency", lat, 28);
    chk("t1_reads", reads - rd0, 16);
    chk("t1_p0", win_pix[7:0], 242);
    chk("t1_p5", win_pix[47:40], 242);
    chk("t1_p15", win_pix[127:120], 188);
    chk("t1_fx", {win_fx_num, win_fx_den}, {6'd0, 6'd14});
    chk("t1_fy", {win_fy_num, win_fy_den}, {6'd0, 6'd14});
    release_win();

    do_req(7, 3, lat);
    chk("t2_latency", lat, 28);
    chk("t2_p0", win_pix[7:0], 244);
    chk("t2_p5", win_pix[47:40], 89);
    chk("t2_p15", win_pix[127:120], 35);
    chk("t2_fx", {win_fx_num, win_fx_den}, {6'd7, 6'd14});
    chk("t2_fy", {win_fy_num, win_fy_den}, {6'd7, 6'd14});
    sv = win_pix;
    stable = 1;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK);
      #1 stable &= win_pix === sv && win_valid && !req_ready && rom_cen &&
                   win_fx_num == 7 && win_fy_num == 7;
    end
    chk("bp_stable", stable, 1);
    release_win();

    do_req(14, 14, lat);
    chk("t3_latency", lat, 28);
    chk("t3_p0", win_pix[7:0], 80);
    chk("t3_p15", win_pix[127:120], 181);
    chk("t3_p3", win_pix[31:24], 80 + 1);
    chk("t3_fx", {win_fx_num, win_fy_num}, 0);
    release_win();

    H0 = 0; V0 = 0; SW = 1; SH = 1; TW = 1; TH = 1;
    do_req(0, 0, lat);
    chk("t4_latency", lat, 28);
    chk("t4_pix", win_pix, 0);
    chk("t4_fracs", {win_fx_num, win_fx_den, win_fy_num, win_fy_den}, 0);
    release_win();

    H0 = 10; V0 = 10; SW = 8; SH = 8; TW = 15; TH = 15;
    @(negedge CLK);
    req_tx = 7; req_ty = 3; req_valid = 1;
    @(posedge CLK);
    #1 req_valid = 0;
    repeat (16) @(posedge CLK);
    #1 chk("pre_rst_cen", rom_cen, 0);
    #2 RST = 1;
    #1;
    chk("mid_rst_cen", rom_cen, 1);
    chk("mid_rst_valid", win_valid, 0);
    chk("mid_rst_ready", req_ready, 1);
    rd0 = reads;
    @(negedge CLK) RST = 0;
    repeat (3) @(posedge CLK);
    #1 chk("mid_rst_noreads", reads - rd0, 0);
    do_req(7, 3, lat);
    chk("t5_latency", lat, 28);
    chk("t5_p5", win_pix[47:40], 89);
    chk("t5_fx", {win_fx_num, win_fy_num}, {6'd7, 6'd7});
    release_win();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
